// File: rtl/pipe_generator.sv
// Scrolling obstacle bitmap for the Flappy Bird game: spawns random-gap pipes at the right edge.
// Latency: grid/occ/step/pass all update on the same edge that ends a TICK_DIV-cycle step period.
// No backpressure: enable low freezes every counter and the bitmap; random is sampled only at spawns.
module pipe_generator #(
  parameter int ROWS     = 16,
  parameter int COLS     = 16,
  parameter int TICK_DIV = 25000,
  parameter int GAP      = 4,
  parameter int SPACING  = 6,
  parameter int BIRD_COL = 3
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enable,
  input  logic [3:0]                 random,
  output logic [ROWS-1:0][COLS-1:0]  grid,
  output logic [COLS-1:0]            occ,
  output logic                       step,
  output logic                       pass
);

  localparam int TW = $clog2(TICK_DIV);
  localparam int SW = $clog2(SPACING);
  localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_DIV - 1);
  localparam logic [SW-1:0] SPAWN_LAST = SW'(SPACING - 1);

  // Run/pause is a pure function of enable; no registered state is needed for it.
  typedef enum logic {PAUSED, RUN} mode_t;
  mode_t mode;

  logic [TW-1:0]              tick_cnt, tick_n;
  logic [SW-1:0]              spawn_cnt, spawn_n;
  logic [ROWS-1:0][COLS-1:0]  grid_n;
  logic [COLS-1:0]            occ_n;
  logic                       step_n, pass_n;
  logic [ROWS-1:0]            spawn_col;
  int                         rnd_m;
  int                         gap_top;

  // Build the column a new pipe would get: all rows lit except the GAP rows starting at gap_top.
  always_comb begin
    rnd_m   = int'(random) % ROWS;
    gap_top = (rnd_m <= ROWS - GAP) ? rnd_m : rnd_m - GAP;
    spawn_col = '0;
    for (int r = 0; r < ROWS; r++) begin
      spawn_col[r] = (r < gap_top) || (r >= gap_top + GAP);
    end
  end

  // Next-state logic: hold everything while paused; on the last tick of a period scroll left,
  // feed the right edge with either a fresh pipe or an empty column, and emit step/pass pulses.
  always_comb begin
    mode      = enable ? RUN : PAUSED;
    tick_n    = tick_cnt;
    spawn_n   = spawn_cnt;
    grid_n    = grid;
    occ_n     = occ;
    step_n    = 1'b0;
    pass_n    = 1'b0;
    case (mode)
      RUN: begin
        if (tick_cnt == TICK_LAST) begin
          tick_n = '0;
          step_n = 1'b1;
          // pass looks at the column before it shifts away from the bird
          pass_n = occ[BIRD_COL];
          for (int c = 0; c < COLS - 1; c++) begin
            occ_n[c] = occ[c+1];
            for (int r = 0; r < ROWS; r++) begin
              grid_n[r][c] = grid[r][c+1];
            end
          end
          if (spawn_cnt == SPAWN_LAST) begin
            spawn_n          = '0;
            occ_n[COLS-1]    = 1'b1;
            for (int r = 0; r < ROWS; r++) begin
              grid_n[r][COLS-1] = spawn_col[r];
            end
          end else begin
            spawn_n          = spawn_cnt + 1'b1;
            occ_n[COLS-1]    = 1'b0;
            for (int r = 0; r < ROWS; r++) begin
              grid_n[r][COLS-1] = 1'b0;
            end
          end
        end else begin
          tick_n = tick_cnt + 1'b1;
        end
      end
      default: ;
    endcase
  end

  // State registers; reset clears the bitmap and restarts both the tick phase and spawn schedule.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tick_cnt  <= '0;
      spawn_cnt <= '0;
      grid      <= '0;
      occ       <= '0;
      step      <= 1'b0;
      pass      <= 1'b0;
    end else begin
      tick_cnt  <= tick_n;
      spawn_cnt <= spawn_n;
      grid      <= grid_n;
      occ       <= occ_n;
      step      <= step_n;
      pass      <= pass_n;
    end
  end

endmodule

// File: tb/tb_pipe_generator.sv
// Bench for pipe_generator: constant gap table, hand-written timing sequences and a randomized run
// against a pipe-list model (each pipe is a column position plus a gap row).
// Outputs are sampled 1 time unit after the rising edge; inputs change at that same point.
module tb_pipe_generator;
  localparam int ROWS = 16, COLS = 16, TICK_DIV = 4, GAP = 4, SPACING = 3, BIRD_COL = 3;

  logic clk = 1'b0;
  logic reset, enable;
  logic [3:0] random;
  logic [ROWS-1:0][COLS-1:0] grid;
  logic [COLS-1:0] occ;
  logic step, pass;

  pipe_generator #(.ROWS(ROWS), .COLS(COLS), .TICK_DIV(TICK_DIV), .GAP(GAP),
                   .SPACING(SPACING), .BIRD_COL(BIRD_COL)) dut (
    .clk(clk), .reset(reset), .enable(enable), .random(random),
    .grid(grid), .occ(occ), .step(step), .pass(pass));

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  typedef struct { int col; int gap; } pipe_t;
  pipe_t pipes[$];
  int    en_cycles, steps;
  logic  m_step, m_pass;
  int    total, bad;

  function automatic int gap_of(input logic [3:0] rnd);
    int v;
    v = int'(rnd);
    return (v <= ROWS - GAP) ? v : v - GAP;
  endfunction

  function automatic logic [ROWS-1:0][COLS-1:0] m_grid();
    logic [ROWS-1:0][COLS-1:0] g;
    g = '0;
    foreach (pipes[i])
      for (int r = 0; r < ROWS; r++)
        g[r][pipes[i].col] = !(r >= pipes[i].gap && r < pipes[i].gap + GAP);
    return g;
  endfunction

  function automatic logic [COLS-1:0] m_occ();
    logic [COLS-1:0] o;
    o = '0;
    foreach (pipes[i]) o[pipes[i].col] = 1'b1;
    return o;
  endfunction

  task automatic model_reset();
    pipes.delete();
    en_cycles = 0;
    steps = 0;
    m_step = 1'b0;
    m_pass = 1'b0;
  endtask

  // One clock edge: every TICK_DIV-th enabled cycle is a step; every SPACING-th step spawns.
  task automatic model_edge(input logic en, input logic [3:0] rnd);
    pipe_t p;
    m_step = 1'b0;
    m_pass = 1'b0;
    if (en) begin
      en_cycles++;
      if (en_cycles % TICK_DIV == 0) begin
        steps++;
        m_step = 1'b1;
        foreach (pipes[i]) if (pipes[i].col == BIRD_COL) m_pass = 1'b1;
        foreach (pipes[i]) pipes[i].col--;
        while (pipes.size() > 0 && pipes[0].col < 0) void'(pipes.pop_front());
        if (steps % SPACING == 0) begin
          p.col = COLS - 1;
          p.gap = gap_of(rnd);
          pipes.push_back(p);
        end
      end
    end
  endtask

  task automatic chk(input string name, input logic [255:0] got, input logic [255:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  task automatic compare_all();
    chk("grid", grid, m_grid());
    chk("occ", 256'(occ), 256'(m_occ()));
    chk("step", 256'(step), 256'(m_step));
    chk("pass", 256'(pass), 256'(m_pass));
  endtask

  // Drive inputs, take one edge, advance the model and compare everything.
  task automatic cyc(input logic en, input logic [3:0] rnd);
    enable = en;
    random = rnd;
    @(posedge clk);
    model_edge(en, rnd);
    #1;
    compare_all();
  endtask

  // Asynchronous reset pulse entirely between edges; outputs must clear before any edge.
  task automatic areset(input string tag);
    reset = 1'b1;
    #2;
    chk({tag, "_grid0"}, grid, '0);
    chk({tag, "_occ0"}, 256'(occ), 256'(0));
    chk({tag, "_step0"}, 256'(step), 256'(0));
    chk({tag, "_pass0"}, 256'(pass), 256'(0));
    reset = 1'b0;
    model_reset();
  endtask

  typedef struct { logic [3:0] rnd; logic [15:0] col; } gap_vec_t;
  gap_vec_t gv[7];

  initial begin
    logic [15:0] col15;
    logic [ROWS-1:0][COLS-1:0] g_save;
    logic [COLS-1:0] o_save;
    logic prev_occ3;
    int first_step, since, pass_at, cnt;
    total = 0;
    bad = 0;
    model_reset();

    gv[0] = '{4'd5,  16'hFE1F};
    gv[1] = '{4'd14, 16'hC3FF};
    gv[2] = '{4'd12, 16'h0FFF};
    gv[3] = '{4'd0,  16'hFFF0};
    gv[4] = '{4'd13, 16'hE1FF};
    gv[5] = '{4'd15, 16'h87FF};
    gv[6] = '{4'd3,  16'hFF87};

    // Reset held with enable high
    reset = 1'b1; enable = 1'b1; random = 4'd0;
    #2;
    chk("rst_grid", grid, '0);
    chk("rst_occ", 256'(occ), 256'(0));
    @(posedge clk); #1;
    chk("rst_hold_step", 256'(step), 256'(0));
    chk("rst_hold_pass", 256'(pass), 256'(0));
    reset = 1'b0;
    model_reset();

    // First step at cycle 4, first spawn at cycle 12
    first_step = -1;
    for (int k = 1; k <= 12; k++) begin
      cyc(1'b1, 4'($urandom));
      if (step && first_step < 0) first_step = k;
    end
    chk("first_step_cycle", 256'(first_step), 256'(4));
    chk("first_spawn_occ15", 256'(occ[15]), 256'(1));

    // Gap mapping table; random toggles every cycle, only the spawn-edge value matters
    for (int v = 0; v < 7; v++) begin
      areset("gap");
      for (int k = 1; k <= 12; k++) cyc(1'b1, (k == 12) ? gv[v].rnd : 4'($urandom));
      for (int r = 0; r < ROWS; r++) col15[r] = grid[r][15];
      chk("gap_col15", 256'(col15), 256'(gv[v].col));
    end

    // Scroll and pass: first pipe passes the bird 13 steps after its spawn
    areset("scroll");
    since = -1; pass_at = -1; prev_occ3 = 1'b0;
    for (int k = 1; k <= 200 && pass_at < 0; k++) begin
      prev_occ3 = occ[BIRD_COL];
      cyc(1'b1, 4'($urandom));
      if (step && since >= 0) since++;
      if (step && since < 0 && occ[15]) since = 0;
      if (pass) begin
        pass_at = since;
        chk("pass_occ3_before", 256'(prev_occ3), 256'(1));
        chk("pass_occ3_after", 256'(occ[BIRD_COL]), 256'(0));
      end
    end
    chk("pass_step_index", 256'(pass_at), 256'(13));

    // Pause at tick phase 2: nothing moves, then step arrives 2 enabled cycles later
    cnt = 0;
    while (!step && cnt < 20) begin cyc(1'b1, 4'($urandom)); cnt++; end
    chk("pause_sync", 256'(step), 256'(1));
    cyc(1'b1, 4'($urandom));
    cyc(1'b1, 4'($urandom));
    g_save = grid; o_save = occ;
    for (int k = 0; k < 10; k++) cyc(1'b0, 4'($urandom));
    chk("pause_grid_hold", grid, g_save);
    chk("pause_occ_hold", 256'(occ), 256'(o_save));
    cnt = 0;
    for (int k = 1; k <= 10 && cnt == 0; k++) begin
      cyc(1'b1, 4'($urandom));
      if (step) cnt = k;
    end
    chk("resume_step_delay", 256'(cnt), 256'(2));

    // Mid-operation reset with pipes on screen; schedule restarts
    for (int k = 0; k < 40; k++) cyc(1'b1, 4'($urandom));
    chk("pipes_on_screen", 256'(occ != 0), 256'(1));
    @(negedge clk);
    areset("midrst");
    first_step = -1;
    for (int k = 1; k <= 12; k++) begin
      cyc(1'b1, 4'($urandom));
      if (step && first_step < 0) first_step = k;
    end
    chk("midrst_first_step", 256'(first_step), 256'(4));
    chk("midrst_spawn_occ15", 256'(occ[15]), 256'(1));

    // Randomized run against the model
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(499) == 0) areset("rnd");
      cyc($urandom_range(9) != 0, 4'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pipe_generator.md
# pipe_generator

Obstacle source for the Flappy Bird game: consumes the 4-bit pseudo-random value from the LFSR stage and maintains a ROWS×COLS obstacle bitmap that scrolls one column left per game step. New one-column pipes are inserted at the right edge with a random gap position. A one-cycle pulse is raised each time a pipe leaves the bird's column. Sits between the LFSR and the collision/score and LED-matrix driver logic.

## Interface
- ROWS, 16, bitmap height; row 0 is the top.
- COLS, 16, bitmap width; column 0 is leftmost; pipes scroll toward column 0.
- TICK_DIV, 25000, clock cycles per scroll step (≥2).
- GAP, 4, gap height in rows (1..ROWS-1).
- SPACING, 6, scroll steps between pipe spawns (≥2).
- BIRD_COL, 3, column the bird occupies (1..COLS-1).
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high; clears all state.
- enable  in  1  game running; low pauses scrolling with state held.
- random  in  4  LFSR output, sampled only on spawn edges.
- grid  out  ROWS×COLS (packed [ROWS-1:0][COLS-1:0])  grid[r][c]=1 means pipe pixel lit.
- occ  out  COLS  occ[c]=1 means column c holds a pipe.
- step  out  1  one-cycle pulse: grid updated by a scroll this cycle.
- pass  out  1  one-cycle pulse: a pipe just left BIRD_COL.

## Operation
- Registers: tick_cnt (clog2(TICK_DIV) bits), spawn_cnt (clog2(SPACING) bits), grid, occ, step, pass.
- Reset values: grid=0, occ=0, step=0, pass=0, tick_cnt=0, spawn_cnt=0.
- States: PAUSED (enable=0) and RUN (enable=1), selected directly by enable with no extra latency.
- PAUSED: tick_cnt, spawn_cnt, grid and occ hold. step=0 and pass=0.
- RUN: tick_cnt increments each cycle and wraps at TICK_DIV-1 to 0. The edge at which tick_cnt==TICK_DIV-1 is a step edge.
- On a step edge, for c in 0..COLS-2: column c takes column c+1 (both grid and occ). Column COLS-1 takes the spawn column if spawn_cnt==SPACING-1; otherwise it is cleared.
- spawn_cnt advances on every step edge and wraps from SPACING-1 to 0. The first pipe is inserted on the SPACING-th step after reset.
- Gap mapping: gap_top = random if random ≤ ROWS-GAP, else random-GAP. With the defaults, 13→9, 14→10, 15→11. For ROWS<16, random is first reduced mod ROWS.
- Spawn column: every row is 1 except rows gap_top..gap_top+GAP-1, which are 0. occ[COLS-1]=1.
- step is registered to 1 on each step edge and 0 otherwise.
- pass is registered to 1 on a step edge when the pre-shift occ[BIRD_COL]=1, and 0 otherwise.
- Column 0 content is discarded on each step edge and produces no output event.
- random is sampled only at the spawn edge; its value on all other cycles is ignored.

## Timing
- Step period is exactly TICK_DIV cycles of enable=1. Paused cycles do not count, and the tick phase is preserved across a pause.
- enable falling on the cycle where tick_cnt==TICK_DIV-1: no step occurs. The step happens on the first enabled edge after enable returns.
- grid, occ, step and pass all change on the same edge. step and pass are valid together with the new grid.
- A pipe inserted at step k reaches column BIRD_COL at step k+(COLS-1-BIRD_COL). pass pulses at step k+(COLS-BIRD_COL).
- Reset asserted mid-run clears all outputs immediately, without waiting for clk. After release, the first step occurs TICK_DIV enabled cycles later.
- The pass of an old pipe and the spawn of a new pipe may fall on the same edge; both take effect.

## Test plan
Bench parameters: TICK_DIV=4, SPACING=3, ROWS=COLS=16, GAP=4, BIRD_COL=3.
- Reset check: assert reset with enable=1 → grid=0, occ=0, step=0, pass=0. Release → step pulses on cycles 4, 8, 12, …; first spawn at the 3rd step (cycle 12).
- Gap mapping: random=5 at spawn → column 15 lit in all rows except 5–8. random=14 → gap rows 10–13. random=12 → gap rows 12–15. random=0 → gap rows 0–3.
- Scroll and pass: track one pipe → it occupies column 15−n after n further steps. pass pulses once, on the 13th step after spawn, together with occ[3] going 1→0. Next spawns occur every 3 steps.
- Pause: drop enable for 10 cycles at tick_cnt=2 → no step, grid and occ unchanged. After re-enable, the next step comes 2 cycles later (tick_cnt resumes at 2).
- Mid-operation reset: pulse reset asynchronously between clock edges with several pipes on screen → grid and occ become 0 before the next edge. The spawn schedule restarts from zero.
- Random ignored off-spawn: toggle random every cycle between spawns → only the value present at the spawn edge affects the new column.
